// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timebase: FSM encoding, display digit
// indices and BCD digit limits.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUNNING  = 2'd1,
        PAUSED   = 2'd2,
        LAP_HOLD = 2'd3
    } sw_state_t;

    localparam logic [2:0] DIG_CS_LO  = 3'd0;
    localparam logic [2:0] DIG_CS_HI  = 3'd1;
    localparam logic [2:0] DIG_SEC_LO = 3'd2;
    localparam logic [2:0] DIG_SEC_HI = 3'd3;
    localparam logic [2:0] DIG_MIN_LO = 3'd4;
    localparam logic [2:0] DIG_MIN_HI = 3'd5;

    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS  = 4'd5;

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit counting 0..LIMIT; carry is asserted combinationally on the
// increment that rolls the digit back to zero.
import stopwatch_pkg::*;

module bcd_digit_counter #(
    parameter logic [3:0] LIMIT = BCD_MAX_UNITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc_en,
    output logic [3:0] value,
    output logic       carry
);

    assign carry = inc_en && (value == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            value <= 4'd0;
        end else if (inc_en) begin
            value <= (value == LIMIT) ? 4'd0 : value + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// MM:SS.cc BCD stopwatch driven by a 10 ms tick, with start/stop, clear and
// lap-freeze; presents one selected digit to the display source mux.
import stopwatch_pkg::*;

module stopwatch_bcd_counter #(
    parameter int MIN_LIMIT = 59,
    parameter int DIGITS    = 6
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       TICK_10MS,
    input  logic       START_STOP,
    input  logic       CLEAR,
    input  logic       LAP,
    input  logic [2:0] DIGIT_SEL,
    output logic [3:0] STW,
    output logic       STOPWATCH_RUN,
    output logic       OVF
);

    localparam logic [3:0] MIN_LIM_HI = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] MIN_LIM_LO = 4'(MIN_LIMIT % 10);

    sw_state_t  state, next_state;
    logic       clr_live, lap_capture, count_en, wrap, min_at_limit;
    logic [3:0] live   [DIGITS];
    logic [3:0] frozen [DIGITS];
    logic       carry  [DIGITS];

    assign count_en     = TICK_10MS && (state == RUNNING || state == LAP_HOLD);
    assign min_at_limit = (live[DIG_MIN_HI] == MIN_LIM_HI) && (live[DIG_MIN_LO] == MIN_LIM_LO);
    // Wrap when the seconds roll over at the minute limit; the BCD-pair carry
    // only fires for MIN_LIMIT=99, where it coincides with the limit compare.
    assign wrap = (carry[DIG_SEC_HI] && min_at_limit) || carry[DIG_MIN_HI];

    bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_cs_lo (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(count_en),
        .value(live[DIG_CS_LO]), .carry(carry[DIG_CS_LO]));
    bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_cs_hi (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(carry[DIG_CS_LO]),
        .value(live[DIG_CS_HI]), .carry(carry[DIG_CS_HI]));
    bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_sec_lo (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(carry[DIG_CS_HI]),
        .value(live[DIG_SEC_LO]), .carry(carry[DIG_SEC_LO]));
    bcd_digit_counter #(.LIMIT(BCD_MAX_TENS)) u_sec_hi (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(carry[DIG_SEC_LO]),
        .value(live[DIG_SEC_HI]), .carry(carry[DIG_SEC_HI]));
    bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_min_lo (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(carry[DIG_SEC_HI]),
        .value(live[DIG_MIN_LO]), .carry(carry[DIG_MIN_LO]));
    bcd_digit_counter #(.LIMIT(BCD_MAX_UNITS)) u_min_hi (
        .clk(CLK), .rst(RST), .clr(clr_live || wrap), .inc_en(carry[DIG_MIN_LO]),
        .value(live[DIG_MIN_HI]), .carry(carry[DIG_MIN_HI]));

    always_comb begin
        next_state  = state;
        clr_live    = 1'b0;
        lap_capture = 1'b0;
        case (state)
            IDLE: begin
                if (START_STOP) next_state = RUNNING;
            end
            RUNNING: begin
                if (START_STOP) begin
                    next_state = PAUSED;
                end else if (LAP) begin
                    next_state  = LAP_HOLD;
                    lap_capture = 1'b1;
                end
            end
            LAP_HOLD: begin
                if (START_STOP)  next_state = PAUSED;
                else if (LAP)    next_state = RUNNING;
            end
            PAUSED: begin
                if (CLEAR) begin
                    next_state = IDLE;
                    clr_live   = 1'b1;
                end else if (START_STOP) begin
                    next_state = RUNNING;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            STOPWATCH_RUN <= 1'b0;
            OVF           <= 1'b0;
            for (int i = 0; i < DIGITS; i++) frozen[i] <= 4'd0;
        end else begin
            state         <= next_state;
            STOPWATCH_RUN <= (next_state != IDLE);
            OVF           <= wrap;
            if (lap_capture) begin
                for (int i = 0; i < DIGITS; i++) frozen[i] <= live[i];
            end
        end
    end

    // Lap hold shows the snapshot while the live count keeps running underneath.
    always_comb begin
        STW = 4'd0;
        case (DIGIT_SEL)
            DIG_CS_LO:  STW = (state == LAP_HOLD) ? frozen[DIG_CS_LO]  : live[DIG_CS_LO];
            DIG_CS_HI:  STW = (state == LAP_HOLD) ? frozen[DIG_CS_HI]  : live[DIG_CS_HI];
            DIG_SEC_LO: STW = (state == LAP_HOLD) ? frozen[DIG_SEC_LO] : live[DIG_SEC_LO];
            DIG_SEC_HI: STW = (state == LAP_HOLD) ? frozen[DIG_SEC_HI] : live[DIG_SEC_HI];
            DIG_MIN_LO: STW = (state == LAP_HOLD) ? frozen[DIG_MIN_LO] : live[DIG_MIN_LO];
            DIG_MIN_HI: STW = (state == LAP_HOLD) ? frozen[DIG_MIN_HI] : live[DIG_MIN_HI];
            default:    STW = 4'd0;
        endcase
    end

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for the stopwatch: a MIN_LIMIT=59 instance plus a MIN_LIMIT=1
// instance on the same inputs so the minute wrap is reachable in a short run.
`timescale 1ns/100ps

module tb_stopwatch_bcd_counter;

    logic       clk = 1'b0;
    logic       rst, tick, start_stop, clear, lap;
    logic [2:0] digit_sel;
    logic [3:0] stw_a, stw_b;
    logic       run_a, run_b, ovf_a, ovf_b;
    logic [23:0] da, db;

    int checks   = 0;
    int failures = 0;

    always #10 clk = ~clk;

    stopwatch_bcd_counter #(.MIN_LIMIT(59), .DIGITS(6)) dut_a (
        .CLK(clk), .RST(rst), .TICK_10MS(tick), .START_STOP(start_stop),
        .CLEAR(clear), .LAP(lap), .DIGIT_SEL(digit_sel), .STW(stw_a),
        .STOPWATCH_RUN(run_a), .OVF(ovf_a));

    stopwatch_bcd_counter #(.MIN_LIMIT(1), .DIGITS(6)) dut_b (
        .CLK(clk), .RST(rst), .TICK_10MS(tick), .START_STOP(start_stop),
        .CLEAR(clear), .LAP(lap), .DIGIT_SEL(digit_sel), .STW(stw_b),
        .STOPWATCH_RUN(run_b), .OVF(ovf_b));

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cycle();
            tick = 1'b0;
        end
    endtask

    task automatic press_ss();
        start_stop = 1'b1;
        cycle();
        start_stop = 1'b0;
    endtask

    task automatic press_lap();
        lap = 1'b1;
        cycle();
        lap = 1'b0;
    endtask

    // Digits packed as min_hi,min_lo,sec_hi,sec_lo,cs_hi,cs_lo nibbles.
    task automatic read_all(output logic [23:0] a, output logic [23:0] b);
        a = '0;
        b = '0;
        for (int i = 0; i < 6; i++) begin
            digit_sel = 3'(i);
            #1;
            a[4*i +: 4] = stw_a;
            b[4*i +: 4] = stw_b;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL reset_digits got=%h exp=%h", da, 24'h000000); end
        checks++;
        if (run_a !== 1'b0) begin failures++; $display("FAIL reset_run got=%b exp=0", run_a); end
        checks++;
        if (ovf_a !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf_a); end
    endtask

    task automatic test_count();
        press_ss();
        checks++;
        if (run_a !== 1'b1) begin failures++; $display("FAIL count_run got=%b exp=1", run_a); end
        tick_n(100);
        digit_sel = 3'd2;
        #1;
        checks++;
        if (stw_a !== 4'h1) begin failures++; $display("FAIL count_sec_lo got=%h exp=1", stw_a); end
        read_all(da, db);
        checks++;
        if (da !== 24'h000100) begin failures++; $display("FAIL count_100 got=%h exp=%h", da, 24'h000100); end
    endtask

    task automatic test_lap();
        tick_n(437);
        read_all(da, db);
        checks++;
        if (da !== 24'h000537) begin failures++; $display("FAIL lap_pre got=%h exp=%h", da, 24'h000537); end
        press_lap();
        for (int k = 0; k < 2; k++) begin
            tick_n(25);
            read_all(da, db);
            checks++;
            if (da !== 24'h000537) begin failures++; $display("FAIL lap_frozen got=%h exp=%h", da, 24'h000537); end
        end
        checks++;
        if (run_a !== 1'b1) begin failures++; $display("FAIL lap_run got=%b exp=1", run_a); end
        press_lap();
        read_all(da, db);
        checks++;
        if (da !== 24'h000587) begin failures++; $display("FAIL lap_release got=%h exp=%h", da, 24'h000587); end
    endtask

    task automatic test_pause_clear();
        press_ss();
        tick_n(20);
        read_all(da, db);
        checks++;
        if (da !== 24'h000587) begin failures++; $display("FAIL pause_hold got=%h exp=%h", da, 24'h000587); end
        checks++;
        if (run_a !== 1'b1) begin failures++; $display("FAIL pause_run got=%b exp=1", run_a); end
        start_stop = 1'b1;
        clear      = 1'b1;
        cycle();
        start_stop = 1'b0;
        clear      = 1'b0;
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL clear_digits got=%h exp=%h", da, 24'h000000); end
        checks++;
        if (run_a !== 1'b0) begin failures++; $display("FAIL clear_run got=%b exp=0", run_a); end
        tick_n(5);
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL clear_idle_tick got=%h exp=%h", da, 24'h000000); end
    endtask

    task automatic test_idle_ignore();
        clear = 1'b1;
        cycle();
        clear = 1'b0;
        press_lap();
        tick_n(3);
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL idle_digits got=%h exp=%h", da, 24'h000000); end
        checks++;
        if (run_a !== 1'b0) begin failures++; $display("FAIL idle_run got=%b exp=0", run_a); end
        start_stop = 1'b1;
        tick       = 1'b1;
        cycle();
        start_stop = 1'b0;
        tick       = 1'b0;
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL start_tick_digits got=%h exp=%h", da, 24'h000000); end
        checks++;
        if (run_a !== 1'b1) begin failures++; $display("FAIL start_tick_run got=%b exp=1", run_a); end
        tick_n(1);
        read_all(da, db);
        checks++;
        if (da !== 24'h000001) begin failures++; $display("FAIL start_first_tick got=%h exp=%h", da, 24'h000001); end
    endtask

    task automatic test_back_to_back();
        tick_n(9);
        press_lap();
        tick_n(5);
        read_all(da, db);
        checks++;
        if (da !== 24'h000010) begin failures++; $display("FAIL b2b_lap got=%h exp=%h", da, 24'h000010); end
        press_ss();
        read_all(da, db);
        checks++;
        if (da !== 24'h000015) begin failures++; $display("FAIL b2b_lap_pause got=%h exp=%h", da, 24'h000015); end
        tick_n(3);
        read_all(da, db);
        checks++;
        if (da !== 24'h000015) begin failures++; $display("FAIL b2b_paused got=%h exp=%h", da, 24'h000015); end
        press_ss();
        start_stop = 1'b1;
        lap        = 1'b1;
        tick       = 1'b1;
        cycle();
        start_stop = 1'b0;
        lap        = 1'b0;
        tick       = 1'b0;
        tick_n(2);
        read_all(da, db);
        checks++;
        if (da !== 24'h000016) begin failures++; $display("FAIL b2b_stop_tick got=%h exp=%h", da, 24'h000016); end
        checks++;
        if (run_a !== 1'b1) begin failures++; $display("FAIL b2b_run got=%b exp=1", run_a); end
    endtask

    task automatic test_minute_wrap();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        press_ss();
        tick_n(5999);
        read_all(da, db);
        checks++;
        if (da !== 24'h005999) begin failures++; $display("FAIL min_pre got=%h exp=%h", da, 24'h005999); end
        tick_n(1);
        read_all(da, db);
        checks++;
        if (da !== 24'h010000) begin failures++; $display("FAIL min_carry got=%h exp=%h", da, 24'h010000); end
        tick_n(5999);
        read_all(da, db);
        checks++;
        if (db !== 24'h015999) begin failures++; $display("FAIL wrap_pre got=%h exp=%h", db, 24'h015999); end
        tick_n(1);
        read_all(da, db);
        checks++;
        if (db !== 24'h000000) begin failures++; $display("FAIL wrap_digits got=%h exp=%h", db, 24'h000000); end
        checks++;
        if (ovf_b !== 1'b1) begin failures++; $display("FAIL wrap_ovf got=%b exp=1", ovf_b); end
        checks++;
        if (run_b !== 1'b1) begin failures++; $display("FAIL wrap_run got=%b exp=1", run_b); end
        checks++;
        if (da !== 24'h020000 || ovf_a !== 1'b0) begin
            failures++; $display("FAIL nowrap_59 got=%h/%b exp=%h/0", da, ovf_a, 24'h020000);
        end
        cycle();
        checks++;
        if (ovf_b !== 1'b0) begin failures++; $display("FAIL wrap_ovf_width got=%b exp=0", ovf_b); end
        tick_n(1);
        read_all(da, db);
        checks++;
        if (db !== 24'h000001) begin failures++; $display("FAIL wrap_continue got=%h exp=%h", db, 24'h000001); end
    endtask

    task automatic test_reset_in_lap();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        press_ss();
        tick_n(1234);
        press_lap();
        tick_n(3);
        read_all(da, db);
        checks++;
        if (da !== 24'h001234) begin failures++; $display("FAIL rlap_frozen got=%h exp=%h", da, 24'h001234); end
        rst  = 1'b1;
        tick = 1'b1;
        cycle();
        rst  = 1'b0;
        tick = 1'b0;
        for (int s = 0; s < 8; s++) begin
            digit_sel = 3'(s);
            #1;
            checks++;
            if (stw_a !== 4'h0) begin failures++; $display("FAIL rlap_stw sel=%0d got=%h exp=0", s, stw_a); end
        end
        checks++;
        if (run_a !== 1'b0 || ovf_a !== 1'b0) begin
            failures++; $display("FAIL rlap_flags got=%b%b exp=00", run_a, ovf_a);
        end
        tick_n(1);
        read_all(da, db);
        checks++;
        if (da !== 24'h000000) begin failures++; $display("FAIL rlap_tick got=%h exp=%h", da, 24'h000000); end
    endtask

    initial begin
        rst        = 1'b1;
        tick       = 1'b0;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        digit_sel  = 3'd0;
        test_reset();
        test_count();
        test_lap();
        test_pause_clear();
        test_idle_ignore();
        test_back_to_back();
        test_minute_wrap();
        test_reset_in_lap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
